multicycle_main_fsm: RTL and testbench

- Main control state machine for the multi-cycle RISC-V datapath variant.
- Sequences fetch, decode, execute, memory and writeback over several cycles for lw, sw, R-type, I-type ALU, beq and jal.
- Drives the shared-ALU operand muxes and `alu_op`. `alu_op` feeds the existing ALU decoder; its encoding is 00 = add, 01 = subtract, 10 = funct-decoded.
- Handles a ready handshake to a single shared instruction/data memory.

---
 rtl/multicycle_main_fsm.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
// Main control FSM for the multi-cycle RISC-V datapath. Sequences fetch,
// decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq
// and jal. It also runs the ready handshake to the shared instruction/data
// memory.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset (state -> FETCH)
//   i_op[6:0]      opcode field of the instruction register
//   i_zero         ALU zero flag (beq decision)
//   i_mem_ready    memory completed the current access this cycle
//   o_mem_req      memory request, held until i_mem_ready
//   o_adr_src      memory address: 0 = PC, 1 = ALUOut
//   o_mem_write    store strobe (only while o_mem_req)
//   o_ir_write     load IR and OldPC
//   o_pc_write     PC enable
//   o_reg_write    register file write enable
//   o_result_src   00 = ALUOut, 01 = Data, 10 = ALUResult
//   o_alu_src_a    00 = PC, 01 = OldPC, 10 = rs1
//   o_alu_src_b    00 = rs2, 01 = ImmExt, 10 = constant 4
//   o_alu_op       00 = add, 01 = subtract, 10 = funct-decoded
//   o_illegal_op   sticky unsupported-opcode flag
//   o_state_dbg    current state encoding (zero-extended)

module multicycle_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [6:0]         i_op,
  input  logic               i_zero,
  input  logic               i_mem_ready,
  output logic               o_mem_req,
  output logic               o_adr_src,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic               o_pc_write,
  output logic               o_reg_write,
  output logic [1:0]         o_result_src,
  output logic [1:0]         o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_alu_op,
  output logic               o_illegal_op,
  output logic [STATE_W-1:0] o_state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       r_illegal_op;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sticky illegal-opcode flag, set on the DECODE -> TRAP transition only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_illegal_op <= 1'b0;
    end else if (r_state == S_DECODE && w_next_state == S_TRAP) begin
      r_illegal_op <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_I:         w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default:      w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_FETCH;  // encodings 12-15 recover
    endcase
  end

  // Output logic (Moore, with ready/zero gating of the PC/IR enables)
  always_comb begin
    o_mem_req    = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_result_src = 2'b00;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        // Reset is folded in so an asserted rst_n with a stray ready can
        // never write PC/IR while the state register is held cleared.
        o_ir_write   = i_mem_ready & i_rst_n;
        o_pc_write   = i_mem_ready & i_rst_n;
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_adr_src   = 1'b1;
        o_mem_write = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b10;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
      end
      S_BEQ: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b01;
        o_pc_write  = i_zero;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_illegal_op = r_illegal_op;
  assign o_state_dbg  = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed testbench for multicycle_main_fsm.
module tb_multicycle_main_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int n_pass;
  int n_total;

  multicycle_main_fsm #(.STATE_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_op         (op),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_mem_req    (mem_req),
    .o_adr_src    (adr_src),
    .o_mem_write  (mem_write),
    .o_ir_write   (ir_write),
    .o_pc_write   (pc_write),
    .o_reg_write  (reg_write),
    .o_result_src (result_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_op     (alu_op),
    .o_illegal_op (illegal_op),
    .o_state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s: got %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 2 time units after the edge
  // and outputs are sampled 1 unit later, well clear of the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    op        = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_state", state_dbg, 4'd0);
    chk("rst_mem_req", mem_req, 1'b1);
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_ir_write", ir_write, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_alu_src_b", alu_src_b, 2'b10);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("fetch_wait_state", state_dbg, 4'd0);
      chk("fetch_wait_pcw", pc_write, 1'b0);
    end
    mem_ready = 1'b1;
    op = 7'b0000011;  // lw
    settle();
    chk("fetch_rdy_irw", ir_write, 1'b1);
    chk("fetch_rdy_pcw", pc_write, 1'b1);

    // ---------------- lw: 0,1,2,3,4,0 ----------------
    tick(); settle();
    chk("lw_s1", state_dbg, 4'd1);
    chk("lw_dec_srca", alu_src_a, 2'b01);
    tick(); settle();
    chk("lw_s2", state_dbg, 4'd2);
    chk("lw_memadr_srca", alu_src_a, 2'b10);
    tick(); settle();
    chk("lw_s3", state_dbg, 4'd3);
    chk("lw_memrd_adr", adr_src, 1'b1);
    chk("lw_memrd_regw", reg_write, 1'b0);
    tick(); settle();
    chk("lw_s4", state_dbg, 4'd4);
    chk("lw_wb_regw", reg_write, 1'b1);
    chk("lw_wb_res", result_src, 2'b01);
    tick(); settle();
    chk("lw_s0", state_dbg, 4'd0);
    chk("lw_fetch_regw", reg_write, 1'b0);

    // ---------------- sw with 2 wait cycles ----------------
    op = 7'b0100011;
    tick(); settle();
    chk("sw_s1", state_dbg, 4'd1);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("sw_s2", state_dbg, 4'd2);
    chk("sw_memadr_memw", mem_write, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_ready = 1'b1;
      settle();
      chk("sw_s5", state_dbg, 4'd5);
      chk("sw_memw", mem_write, 1'b1);
      chk("sw_adr", adr_src, 1'b1);
      chk("sw_req", mem_req, 1'b1);
    end
    tick(); settle();
    chk("sw_s0", state_dbg, 4'd0);

    // ---------------- beq taken ----------------
    op = 7'b1100011;
    zero = 1'b1;
    tick(); settle();
    chk("beq1_s1", state_dbg, 4'd1);
    chk("beq1_dec_pcw", pc_write, 1'b0);
    tick(); settle();
    chk("beq1_s9", state_dbg, 4'd9);
    chk("beq1_pcw", pc_write, 1'b1);
    chk("beq1_aluop", alu_op, 2'b01);
    tick(); settle();
    chk("beq1_s0", state_dbg, 4'd0);

    // ---------------- beq not taken ----------------
    zero = 1'b0;
    tick(); settle();
    chk("beq2_s1", state_dbg, 4'd1);
    tick(); settle();
    chk("beq2_s9", state_dbg, 4'd9);
    chk("beq2_pcw", pc_write, 1'b0);
    chk("beq2_aluop", alu_op, 2'b01);
    tick(); settle();
    chk("beq2_s0", state_dbg, 4'd0);

    // ---------------- R-type ----------------
    op = 7'b0110011;
    tick(); settle();
    chk("r_s1", state_dbg, 4'd1);
    tick(); settle();
    chk("r_s6", state_dbg, 4'd6);
    chk("r_aluop", alu_op, 2'b10);
    chk("r_srcb", alu_src_b, 2'b00);
    chk("r_exec_regw", reg_write, 1'b0);
    tick(); settle();
    chk("r_s8", state_dbg, 4'd8);
    chk("r_wb_regw", reg_write, 1'b1);
    chk("r_wb_res", result_src, 2'b00);
    tick(); settle();
    chk("r_s0", state_dbg, 4'd0);

    // ---------------- I-type ----------------
    op = 7'b0010011;
    tick(); tick(); settle();
    chk("i_s7", state_dbg, 4'd7);
    chk("i_srcb", alu_src_b, 2'b01);
    tick(); settle();
    chk("i_s8", state_dbg, 4'd8);
    tick(); settle();
    chk("i_s0", state_dbg, 4'd0);

    // ---------------- jal ----------------
    op = 7'b1101111;
    tick(); settle();
    chk("jal_s1", state_dbg, 4'd1);
    tick(); settle();
    chk("jal_s10", state_dbg, 4'd10);
    chk("jal_pcw", pc_write, 1'b1);
    chk("jal_srcb", alu_src_b, 2'b10);
    chk("jal_srca", alu_src_a, 2'b01);
    tick(); settle();
    chk("jal_s8", state_dbg, 4'd8);
    chk("jal_regw", reg_write, 1'b1);
    tick(); settle();
    chk("jal_s0", state_dbg, 4'd0);

    // ---------------- reset mid-writeback ----------------
    op = 7'b0000011;
    tick(); tick(); tick(); tick(); settle();
    chk("midrst_s4", state_dbg, 4'd4);
    chk("midrst_regw_before", reg_write, 1'b1);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    settle();
    chk("midrst_state", state_dbg, 4'd0);
    chk("midrst_regw", reg_write, 1'b0);
    chk("midrst_pcw", pc_write, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // ---------------- illegal opcode -> TRAP ----------------
    op = 7'b1111111;
    tick(); settle();
    chk("trap_s1", state_dbg, 4'd1);
    chk("trap_dec_illegal", illegal_op, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      chk("trap_state", state_dbg, 4'd11);
      chk("trap_illegal", illegal_op, 1'b1);
      chk("trap_req", mem_req, 1'b0);
    end
    rst_n = 1'b0;
    mem_ready = 1'b0;
    settle();
    chk("trap_rst_state", state_dbg, 4'd0);
    chk("trap_rst_illegal", illegal_op, 1'b0);
    chk("trap_rst_req", mem_req, 1'b1);
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
